// File: rtl/audio_fifo_i2s_pkg.sv
// rtl/audio_fifo_i2s_pkg.sv - shared constants and types for the audio output path
// Purpose: frame geometry of the I2S serializer and the default sample type.
// Ports: none (package).
package audio_pkg;

    localparam int SLOT_BITS        = 32;
    localparam int FRAME_BITS       = 64;
    localparam int SAMPLE_W_DEFAULT = 24;

    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int SLOT_POS_W = $clog2(SLOT_BITS);

    typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/audio_fifo_i2s_if.sv
// rtl/audio_fifo_i2s_if.sv - control, push and I2S signal bundle of audio_fifo_i2s
// Purpose: groups the synth-core push side, flag controls and codec pins.
// Ports (signals):
//   enable, ld_fifo, tone, clr_flags          driven by master
//   fifo_full, fifo_level, overflow, underflow,
//   i2s_bclk, i2s_lrclk, i2s_sdata            driven by slave (the block)
interface audio_fifo_i2s_if #(
    parameter int DEPTH = 16
);

    logic                     enable;
    logic                     ld_fifo;
    logic [31:0]              tone;
    logic                     clr_flags;
    logic                     fifo_full;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     overflow;
    logic                     underflow;
    logic                     i2s_bclk;
    logic                     i2s_lrclk;
    logic                     i2s_sdata;

    modport master (
        output enable, ld_fifo, tone, clr_flags,
        input  fifo_full, fifo_level, overflow, underflow,
        input  i2s_bclk, i2s_lrclk, i2s_sdata
    );

    modport slave (
        input  enable, ld_fifo, tone, clr_flags,
        output fifo_full, fifo_level, overflow, underflow,
        output i2s_bclk, i2s_lrclk, i2s_sdata
    );

endinterface

// File: rtl/audio_fifo_i2s_fifo.sv
// rtl/audio_fifo_i2s_fifo.sv - synchronous sample FIFO with drop-on-full push
// Purpose: circular buffer between the synth core and the serializer.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push         push request; ignored while full
//   i_pop          pop request; ignored while empty
//   i_din          data to push
//   o_dout         head entry (combinational)
//   o_count        occupancy, reads DEPTH when full
//   o_full/o_empty occupancy decodes of the count register
module sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 24
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_din,
    output logic [WIDTH-1:0]       o_dout,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Full is taken from the registered count, so a push coinciding with a
    // pop on a full FIFO is still dropped.
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/audio_fifo_i2s.sv
// rtl/audio_fifo_i2s.sv - sample FIFO draining one mono sample per frame into a Philips I2S serializer
// Purpose: buffers synth samples, generates BCLK/LRCLK, shifts each sample
//          MSB first into both channel slots, keeps sticky debug flags.
// Ports:
//   i_clk   system clock
//   i_rst   asynchronous active-high reset
//   bus     audio_fifo_i2s_if.slave: enable, ld_fifo, tone, clr_flags in;
//           fifo_full, fifo_level, overflow, underflow, i2s_* out
module audio_fifo_i2s
    import audio_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int BCLK_DIV = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    audio_fifo_i2s_if.slave  bus
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]        r_div_cnt;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic                    r_bclk;
    logic                    r_lrclk;
    logic                    r_sdata;
    logic [SAMPLE_W-1:0]     r_sample;
    logic                    r_overflow;
    logic                    r_underflow;

    logic                    w_tick;
    logic                    w_fall;
    logic                    w_frame_start;
    logic [BIT_CNT_W-1:0]    w_bit_next;
    logic [SLOT_POS_W-1:0]   w_slot_pos;
    logic [SLOT_BITS-1:0]    w_slot_word;
    logic                    w_slot_bit;
    logic [SAMPLE_W-1:0]     w_head;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_unused_tone;

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (bus.ld_fifo),
        .i_pop   (w_frame_start),
        .i_din   (bus.tone[SAMPLE_W-1:0]),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_unused_tone = ^bus.tone[31:SAMPLE_W];

    assign w_tick        = (r_div_cnt == DIV_LAST);
    assign w_fall        = bus.enable && w_tick && r_bclk;
    assign w_frame_start = w_fall && (r_bit_cnt == '1);
    assign w_bit_next    = r_bit_cnt + BIT_CNT_W'(1);
    assign w_slot_pos    = w_bit_next[SLOT_POS_W-1:0];

    // Slot word: position 0 is the one-bit I2S delay, positions 1..SAMPLE_W
    // carry the sample MSB first, the rest is zero padding.
    assign w_slot_word[0] = 1'b0;
    for (genvar g = 1; g < SLOT_BITS; g++) begin : g_slot
        if (g <= SAMPLE_W) begin : g_data
            assign w_slot_word[g] = r_sample[SAMPLE_W-g];
        end else begin : g_pad
            assign w_slot_word[g] = 1'b0;
        end
    end
    assign w_slot_bit = w_slot_word[w_slot_pos];

    // Serializer updates happen only on BCLK falling toggles. At frame start
    // the slot bit is always the delay bit, so the stale sample_reg is harmless.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '1;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
            r_sample  <= '0;
        end else if (!bus.enable) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '1;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
            r_sample  <= '0;
        end else begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_bclk    <= !r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_next;
                r_lrclk   <= w_bit_next[BIT_CNT_W-1];
                r_sdata   <= w_slot_bit;
            end
            if (w_frame_start) begin
                r_sample <= w_empty ? '0 : w_head;
            end
        end
    end

    // A set event in the same cycle as clr_flags keeps the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.ld_fifo && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_start && w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_flags) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.fifo_full  = w_full;
    assign bus.fifo_level = w_count;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;
    assign bus.i2s_bclk   = r_bclk;
    assign bus.i2s_lrclk  = r_lrclk;
    assign bus.i2s_sdata  = r_sdata;

endmodule

// File: doc/audio_fifo_i2s.md
Name: audio_fifo_i2s

Overview:
Downstream stage of the synth core. Buffers the 32-bit mixed samples written with TONE/LD_FIFO in a synchronous FIFO and returns FIFO_FULL as back-pressure. Drains one sample per audio frame into a Philips I2S serializer driving the codec DAC. The sample is mono and is duplicated to the left and right channels. Sticky overflow and underflow flags are provided for debug.

Parameters:
DEPTH, 16, FIFO entries (power of two)
SAMPLE_W, 24, audio bits taken from TONE[SAMPLE_W-1:0], two's complement
BCLK_DIV, 8, CLK cycles per BCLK half-period (BCLK_DIV >= 2)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
ENABLE  in  1  serializer run; FIFO writes accepted regardless
LD_FIFO  in  1  push strobe from synth core, one cycle
TONE  in  32  sample to push
CLR_FLAGS  in  1  clears OVERFLOW and UNDERFLOW
FIFO_FULL  out  1  count == DEPTH (combinational from count register)
FIFO_LEVEL  out  $clog2(DEPTH)+1  current count
OVERFLOW  out  1  sticky: push dropped while full
UNDERFLOW  out  1  sticky: frame started while empty
I2S_BCLK  out  1  bit clock
I2S_LRCLK  out  1  0 = left, 1 = right
I2S_SDATA  out  1  serial data

Behaviour:
- Clock and reset: one clock CLK; RESET is asynchronous and active-high. On reset: count = 0, read and write pointers = 0, OVERFLOW = 0, UNDERFLOW = 0, BCLK = 0, LRCLK = 0, SDATA = 0, div_cnt = 0, bit_cnt = 63, shift register = 0.
- Reset mid-frame: the frame is abandoned and FIFO contents are discarded.
- Push:
  - Accepted iff LD_FIFO && !FIFO_FULL, with FIFO_FULL evaluated before any same-cycle pop.
  - LD_FIFO while full drops the sample, sets OVERFLOW and leaves count unchanged.
- Pop: occurs only at a frame start (see below) when count > 0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Read data is the combinational head entry.
- Clock generation when ENABLE = 1:
  - div_cnt counts 0..BCLK_DIV-1.
  - At BCLK_DIV-1, div_cnt returns to 0 and BCLK toggles.
- BCLK falling event (1 -> 0 toggle): all serializer updates happen in the same CLK cycle as the toggle.
  - bit_cnt increments mod 64.
  - LRCLK = new bit_cnt[5].
  - SDATA takes the slot bit for the new bit_cnt.
- Frame start (bit_cnt 63 -> 0):
  - If count > 0: pop the FIFO and load sample_reg with head[SAMPLE_W-1:0].
  - If empty: load sample_reg = 0 and set UNDERFLOW.
- Slot mapping, with p = bit_cnt[4:0] (identical for both channels):
  - p = 0: 0. The one-BCLK I2S delay; the padding LSB of the previous slot.
  - p = 1..SAMPLE_W: sample_reg bit (SAMPLE_W - p), MSB first.
  - p > SAMPLE_W: 0.
- Rising BCLK toggles change nothing except BCLK.
- Timing after reset:
  - First BCLK rise occurs BCLK_DIV cycles after reset release.
  - First fall, and hence the first pop, occurs 2*BCLK_DIV cycles after reset release.
  - Frame period is 128*BCLK_DIV CLK cycles.
- ENABLE:
  - ENABLE = 0 forces div_cnt, bit_cnt, BCLK, LRCLK, SDATA and sample_reg to their reset values on the next edge; no pops occur.
  - ENABLE rising restarts the sequence exactly as after reset.
- CLR_FLAGS clears both sticky flags. A set event in the same cycle wins (flag stays 1).
- Flag width rule: FIFO_LEVEL is the count register; it reads DEPTH when full.

Decomposition:
- Package audio_pkg holds:
  - SLOT_BITS = 32 and FRAME_BITS = 64
  - default SAMPLE_W
  - typedef sample_t = logic signed [SAMPLE_W-1:0]
- Sub-module sample_fifo (parameters DEPTH, WIDTH):
  - inputs: push, pop, din
  - outputs: dout (head), count, full, empty
  - sample_fifo implements the push-while-full drop rule.
- audio_fifo_i2s contains the clock divider, bit counter, shift/slot logic and flags.

Test Plan:
- Reset, then ENABLE = 1 with BCLK_DIV = 8 and an empty FIFO:
  - BCLK first rises at cycle 8 and falls at cycle 16.
  - UNDERFLOW = 1 at cycle 16.
  - SDATA stays 0 for a full 1024-cycle frame.
  - LRCLK high for bit_cnt 32..63.
- Push TONE = 32'h00ABCDEF, ENABLE = 1:
  - Left and right slots each carry 0, then 1010_1011_1100_1101_1110_1111 at p = 1..24, then zeros.
  - FIFO_LEVEL goes 1 -> 0 at the first frame start.
- With ENABLE = 0, push 16 samples:
  - FIFO_FULL = 1 and FIFO_LEVEL = 16.
  - A 17th LD_FIFO sets OVERFLOW and FIFO_LEVEL stays 16.
  - CLR_FLAGS clears OVERFLOW.
- FIFO full with LD_FIFO coinciding with a frame-start pop:
  - The push is dropped, OVERFLOW = 1, FIFO_LEVEL = 15.
  - With count = 5, the same coincidence keeps FIFO_LEVEL = 5.
- Push 20 distinct values across 20 frames with writes interleaved:
  - Serialized order matches push order.
  - Pointers wrap past 15 correctly.
- Assert RESET mid-right-channel with FIFO_LEVEL = 3:
  - All outputs return to their reset values immediately, without waiting for CLK.
  - FIFO_LEVEL = 0.
  - After release, timing restarts per the first scenario.
